// File: rtl/option_fifo_server_pkg.sv
// Shared constants and the server state encoding for the option FIFO server
// and its storage.
package option_fifo_server_pkg;

    localparam int OPT_W_DEFAULT   = 16;
    localparam int DEPTH_DEFAULT   = 1024;
    localparam int MAX_ROWS        = 32;
    localparam int MAX_COLS        = 32;
    localparam int MAX_NUM_OPTIONS = 960;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SERVE = 2'd2,
        ST_DONE  = 2'd3
    } server_state_t;

endpackage

// File: rtl/option_fifo_server_ram.sv
// Simple dual-port word store: one write port, one registered read port
// (read-first), shaped for block-RAM inference.
module option_fifo_server_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    // Write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read; holds its value while i_re is low.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/option_fifo_server.sv
// Circular option store between the board parser and the line solver:
// loaded once, then serves head words on pop and re-enqueues words on push.
module option_fifo_server
    import option_fifo_server_pkg::*;
#(
    parameter int OPT_W = OPT_W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load_valid,
    input  logic [OPT_W-1:0]         i_load_data,
    input  logic                     i_load_done,
    output logic                     o_started,
    input  logic                     i_pop,
    output logic [OPT_W-1:0]         o_option,
    input  logic                     i_push,
    input  logic [OPT_W-1:0]         i_push_data,
    input  logic                     i_solved,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    server_state_t    r_state;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_started;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_byp_valid;
    logic [OPT_W-1:0] r_byp_data;

    logic             w_empty;
    logic             w_full;
    logic             w_serve;
    logic             w_load_cyc;
    logic             w_load_we;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic             w_we;
    logic [OPT_W-1:0] w_wdata;
    logic [AW-1:0]    w_next_rd_ptr;
    logic             w_rd_en;
    logic             w_fwd;
    logic [OPT_W-1:0] w_ram_rdata;

    // Accept/reject decisions for this cycle; a pop on an empty queue with a
    // concurrent push is absorbed so the pushed word becomes the new head.
    always_comb begin
        w_empty    = (r_count == CW'(0));
        w_full     = (r_count == CW'(DEPTH));
        w_serve    = (r_state == ST_SERVE) && !i_solved;
        w_load_cyc = (r_state == ST_IDLE) || (r_state == ST_LOAD);
        w_load_we  = w_load_cyc && i_load_valid && !w_full;
        w_pop_ok   = w_serve && i_pop && !w_empty;
        w_push_ok  = w_serve && i_push && (!w_full || w_pop_ok);
        w_we       = !rst && (w_load_we || w_push_ok);
        if (w_push_ok) begin
            w_wdata = i_push_data;
        end else begin
            w_wdata = i_load_data;
        end
        w_next_rd_ptr = r_rd_ptr + AW'(w_pop_ok);
        w_rd_en = (r_state == ST_LOAD) || (r_state == ST_SERVE) ||
                  ((r_state == ST_IDLE) && i_load_valid);
        w_fwd   = w_we && (r_wr_ptr == w_next_rd_ptr);
    end

    option_fifo_server_ram #(
        .W     (OPT_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_re    (w_rd_en),
        .i_raddr (w_next_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    // State machine, pointers, occupancy, sticky flags and head bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rd_ptr    <= AW'(0);
            r_wr_ptr    <= AW'(0);
            r_count     <= CW'(0);
            r_started   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_byp_valid <= 1'b1;
            r_byp_data  <= OPT_W'(0);
        end else begin
            if (w_rd_en) begin
                r_byp_valid <= w_fwd;
                r_byp_data  <= w_wdata;
            end
            if (w_load_cyc && i_load_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_serve && i_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (w_serve && i_pop && w_empty && !i_push) begin
                r_underflow <= 1'b1;
            end
            if (w_load_we || w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_load_we || w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            case (r_state)
                ST_IDLE: begin
                    if (i_load_done) begin
                        r_state   <= ST_SERVE;
                        r_started <= 1'b1;
                    end else if (i_load_valid) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (i_load_done) begin
                        r_state   <= ST_SERVE;
                        r_started <= 1'b1;
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_SERVE: begin
                    if (i_solved) begin
                        r_state   <= ST_DONE;
                        r_started <= 1'b0;
                    end else begin
                        r_state <= ST_SERVE;
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_rd_ptr <= AW'(0);
                    r_wr_ptr <= AW'(0);
                    r_count  <= CW'(0);
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_option    = r_byp_valid ? r_byp_data : w_ram_rdata;
    assign o_started   = r_started;
    assign o_count     = r_count;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_option_fifo_server.sv
// Scoreboard bench for option_fifo_server: a queue-based reference model
// predicts each cycle's outputs, a monitor compares them on the falling edge.
module tb_option_fifo_server;

    localparam int OPT_W = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_valid = 1'b0;
    logic [OPT_W-1:0] load_data = '0;
    logic             load_done = 1'b0;
    logic             started;
    logic             pop = 1'b0;
    logic [OPT_W-1:0] option;
    logic             push = 1'b0;
    logic [OPT_W-1:0] push_data = '0;
    logic             solved = 1'b0;
    logic [CW-1:0]    count;
    logic             empty, full, overflow, underflow;

    always #5 clk = ~clk;

    option_fifo_server #(.OPT_W(OPT_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_load_valid (load_valid),
        .i_load_data  (load_data),
        .i_load_done  (load_done),
        .o_started    (started),
        .i_pop        (pop),
        .o_option     (option),
        .i_push       (push),
        .i_push_data  (push_data),
        .i_solved     (solved),
        .o_count      (count),
        .o_empty      (empty),
        .o_full       (full),
        .o_overflow   (overflow),
        .o_underflow  (underflow)
    );

    typedef struct {
        int cyc;
        int count;
        bit empty, full, started, ovf, unf, opt_chk;
        int opt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: the queue contents in order, plus phase and flags.
    logic [OPT_W-1:0] mq[$];
    int ph = 0;          // 0 idle, 1 loading, 2 serving, 3 finished
    bit m_started = 0, m_ovf = 0, m_unf = 0;

    task automatic cmp(input string nm, input int c, input int act, input int want);
        if (act != want) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, c, act, want);
        end
    endtask

    task automatic step(input bit r, input bit lv, input logic [OPT_W-1:0] ld, input bit dn,
                        input bit p, input bit pu, input logic [OPT_W-1:0] pd, input bit sv);
        exp_t e;
        rst = r; load_valid = lv; load_data = ld; load_done = dn;
        pop = p; push = pu; push_data = pd; solved = sv;
        if (r) begin
            mq.delete(); ph = 0; m_started = 0; m_ovf = 0; m_unf = 0;
        end else begin
            case (ph)
                0, 1: begin
                    if (lv) begin
                        if (mq.size() < DEPTH) mq.push_back(ld);
                        else m_ovf = 1;
                    end
                    if (dn) begin ph = 2; m_started = 1; end
                    else if (lv) ph = 1;
                end
                2: begin
                    if (sv) begin
                        ph = 3; m_started = 0;
                    end else if (p && pu) begin
                        if (mq.size() != 0) void'(mq.pop_front());
                        mq.push_back(pd);
                    end else if (p) begin
                        if (mq.size() == 0) m_unf = 1;
                        else void'(mq.pop_front());
                    end else if (pu) begin
                        if (mq.size() == DEPTH) m_ovf = 1;
                        else mq.push_back(pd);
                    end
                end
                default: begin
                    ph = 0; mq.delete();
                end
            endcase
        end
        e.cyc = cyc; e.count = mq.size(); e.empty = (mq.size() == 0);
        e.full = (mq.size() == DEPTH); e.started = m_started; e.ovf = m_ovf; e.unf = m_unf;
        e.opt_chk = r || (mq.size() != 0);
        e.opt = r ? 0 : ((mq.size() != 0) ? int'(mq[0]) : 0);
        exp_q.push_back(e);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic ld(input logic [OPT_W-1:0] d); step(0, 1, d, 0, 0, 0, 0, 0); endtask
    task automatic done(); step(0, 0, 0, 1, 0, 0, 0, 0); endtask
    task automatic popw(); step(0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic pushw(input logic [OPT_W-1:0] d); step(0, 0, 0, 0, 0, 1, d, 0); endtask
    task automatic both(input logic [OPT_W-1:0] d); step(0, 0, 0, 0, 1, 1, d, 0); endtask
    task automatic reset(); step(1, 0, 0, 0, 0, 0, 0, 0); endtask

    // Monitor: compare one predicted record per cycle, after the DUT settles.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                cmp("count", e.cyc, int'(count), e.count);
                cmp("empty", e.cyc, int'(empty), int'(e.empty));
                cmp("full", e.cyc, int'(full), int'(e.full));
                cmp("started", e.cyc, int'(started), int'(e.started));
                cmp("overflow", e.cyc, int'(overflow), int'(e.ovf));
                cmp("underflow", e.cyc, int'(underflow), int'(e.unf));
                if (e.opt_chk) cmp("option", e.cyc, int'(option), e.opt);
            end
        end
    end

    initial begin
        logic [OPT_W-1:0] words [5];
        words[0] = 16'h0003; words[1] = 16'h0005; words[2] = 16'h000A;
        words[3] = 16'h0007; words[4] = 16'h001F;

        reset(); reset(); idle();
        // Basic load and drain, then pop on empty.
        for (int i = 0; i < 5; i++) ld(words[i]);
        done();
        for (int i = 0; i < 5; i++) popw();
        popw(); idle();
        step(0, 0, 0, 0, 0, 0, 0, 1); idle(); idle();

        // Empty start, push+pop on empty, then fill to full and overflow.
        reset(); done();
        both(16'h002A); idle();
        for (int i = 1; i < DEPTH; i++) pushw(16'h0100 + 16'(i));
        pushw(16'h0BAD);
        both(16'h0077); idle();
        for (int i = 0; i < DEPTH + 1; i++) popw();

        // Pointer wrap.
        reset();
        for (int i = 0; i < 6; i++) ld(16'h0040 + 16'(i));
        done();
        for (int i = 0; i < 6; i++) popw();
        for (int i = 0; i < 5; i++) pushw(16'h0011 + 16'(i));
        for (int i = 0; i < 5; i++) popw();

        // Reset in the middle of serving with a push in flight.
        reset();
        for (int i = 0; i < 4; i++) ld(16'h0090 + 16'(i));
        step(0, 1, 16'h0094, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 16'h00EE, 0);
        idle();

        // Randomised episodes, alternating full reset and solve-driven restart.
        for (int ep = 0; ep < 8; ep++) begin
            int nl;
            if (ep % 2 == 0) reset();
            nl = $urandom_range(0, DEPTH + 2);
            for (int i = 0; i < nl; i++)
                step(0, ($urandom_range(0, 3) != 0), 16'($urandom), 0, 0, 0, 0, 0);
            step(0, $urandom_range(0, 1) == 1, 16'($urandom), 1, 0, 0, 0, 0);
            for (int i = 0; i < 150; i++)
                step(0, 0, 0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     16'($urandom), 0);
            step(0, 0, 0, 0, 0, 0, 0, 1);
            idle(); idle();
        end

        @(negedge clk); @(negedge clk);
        n_vec++;
        cmp("drain", cyc, exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
